// File: rtl/fp_rnd_arb.sv
// fp_rnd_arb: buffers FMA and FDIV/FSQRT results and feeds the FP rounder.
// Define FP_RND_ARB_TAG_EN to carry a destination tag with every record.
module fp_rnd_arb #(
  parameter int DEPTH        = 4,
  parameter int AFULL_MARGIN = 2,
  parameter int STARVE_MAX   = 8,
  parameter int TAG_W        = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fma_valid_i,
  input  logic [84:0]      fma_rnd_i,
  input  logic             fdiv_valid_i,
  input  logic [84:0]      fdiv_rnd_i,
`ifdef FP_RND_ARB_TAG_EN
  input  logic [TAG_W-1:0] fma_tag_i,
  input  logic [TAG_W-1:0] fdiv_tag_i,
  output logic [TAG_W-1:0] rnd_tag_o,
`endif
  output logic             fdiv_ready_o,
  output logic             fma_afull_o,
  output logic             rnd_valid_o,
  input  logic             rnd_ready_i,
  output logic [84:0]      rnd_o,
  output logic             rnd_src_o,
  output logic             overflow_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
`ifdef FP_RND_ARB_TAG_EN
  localparam int EW = 85 + TAG_W;
`else
  localparam int EW = 85;
`endif

  typedef logic [EW-1:0] ent_t;
  typedef logic [PW:0]   ptr_t;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TAG_W < 1) begin : g_bad_param
    $error("fp_rnd_arb: illegal parameter set");
  end

  ent_t fma_in, fdiv_in;
`ifdef FP_RND_ARB_TAG_EN
  assign fma_in  = {fma_tag_i, fma_rnd_i};
  assign fdiv_in = {fdiv_tag_i, fdiv_rnd_i};
`else
  assign fma_in  = fma_rnd_i;
  assign fdiv_in = fdiv_rnd_i;
`endif

  ent_t          fma_mem_q  [DEPTH];
  ent_t          fdiv_mem_q [DEPTH];
  ptr_t          fma_wp_q, fma_rp_q;
  ptr_t          fdiv_wp_q, fdiv_rp_q;
  logic [SW-1:0] starve_q, starve_d;
  logic          out_v_q, out_v_d;
  ent_t          out_q, out_d;
  logic          src_q, src_d;
  logic          ovf_q;

  ptr_t fma_cnt, fdiv_cnt;
  logic fma_empty, fma_full;
  logic fdiv_empty, fdiv_full;
  logic load, fdiv_in_ok;
  logic fma_c, fdiv_c, pick_fdiv;
  logic gnt_fma, gnt_fdiv;
  logic fma_pop, fma_byp, fma_push, fma_drop;
  logic fdiv_pop, fdiv_byp, fdiv_push;

  assign fma_cnt    = fma_wp_q - fma_rp_q;
  assign fdiv_cnt   = fdiv_wp_q - fdiv_rp_q;
  assign fma_empty  = fma_wp_q == fma_rp_q;
  assign fdiv_empty = fdiv_wp_q == fdiv_rp_q;
  assign fma_full   = (fma_wp_q[PW] != fma_rp_q[PW]) &&
                      (fma_wp_q[PW-1:0] == fma_rp_q[PW-1:0]);
  assign fdiv_full  = (fdiv_wp_q[PW] != fdiv_rp_q[PW]) &&
                      (fdiv_wp_q[PW-1:0] == fdiv_rp_q[PW-1:0]);

  // Candidates are FIFO heads, or the live input when its FIFO is empty.
  assign load       = !out_v_q || rnd_ready_i;
  assign fdiv_in_ok = fdiv_valid_i && !fdiv_full;
  assign fma_c      = !fma_empty || fma_valid_i;
  assign fdiv_c     = !fdiv_empty || fdiv_in_ok;
  assign pick_fdiv  = fdiv_c && (!fma_c || starve_q >= SW'(STARVE_MAX));
  assign gnt_fma    = load && fma_c && !pick_fdiv;
  assign gnt_fdiv   = load && pick_fdiv;

  assign fma_pop   = gnt_fma && !fma_empty;
  assign fma_byp   = gnt_fma && fma_empty;
  assign fdiv_pop  = gnt_fdiv && !fdiv_empty;
  assign fdiv_byp  = gnt_fdiv && fdiv_empty;
  assign fma_push  = fma_valid_i && !fma_byp && (!fma_full || fma_pop);
  assign fma_drop  = fma_valid_i && !fma_byp && fma_full && !fma_pop;
  assign fdiv_push = fdiv_in_ok && !fdiv_byp;

  always_comb begin
    out_v_d  = out_v_q;
    out_d    = out_q;
    src_d    = src_q;
    starve_d = starve_q;
    if (load) begin
      out_v_d = gnt_fma || gnt_fdiv;
    end
    if (gnt_fdiv) begin
      out_d    = fdiv_empty ? fdiv_in : fdiv_mem_q[fdiv_rp_q[PW-1:0]];
      src_d    = 1'b1;
      starve_d = '0;
    end else if (gnt_fma) begin
      out_d = fma_empty ? fma_in : fma_mem_q[fma_rp_q[PW-1:0]];
      src_d = 1'b0;
      if (fdiv_c && starve_q != SW'(STARVE_MAX)) begin
        starve_d = starve_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fma_push) begin
      fma_mem_q[fma_wp_q[PW-1:0]] <= fma_in;
    end
    if (fdiv_push) begin
      fdiv_mem_q[fdiv_wp_q[PW-1:0]] <= fdiv_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fma_wp_q  <= '0;
      fma_rp_q  <= '0;
      fdiv_wp_q <= '0;
      fdiv_rp_q <= '0;
      starve_q  <= '0;
      out_v_q   <= 1'b0;
      out_q     <= '0;
      src_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (fma_push) fma_wp_q <= fma_wp_q + ptr_t'(1);
      if (fma_pop) fma_rp_q <= fma_rp_q + ptr_t'(1);
      if (fdiv_push) fdiv_wp_q <= fdiv_wp_q + ptr_t'(1);
      if (fdiv_pop) fdiv_rp_q <= fdiv_rp_q + ptr_t'(1);
      if (fma_drop) ovf_q <= 1'b1;
      starve_q <= starve_d;
      out_v_q  <= out_v_d;
      out_q    <= out_d;
      src_q    <= src_d;
    end
  end

  assign fdiv_ready_o = !fdiv_full;
  assign fma_afull_o  = fma_cnt >= ptr_t'(DEPTH - AFULL_MARGIN);
  assign rnd_valid_o  = out_v_q;
  assign rnd_o        = out_q[84:0];
  assign rnd_src_o    = src_q;
  assign overflow_o   = ovf_q;
`ifdef FP_RND_ARB_TAG_EN
  assign rnd_tag_o    = out_q[EW-1:85];
`endif

  logic unused_cnt;
  assign unused_cnt = ^fdiv_cnt;
endmodule

// File: tb/tb_fp_rnd_arb.sv
// tb_fp_rnd_arb: directed and randomized checks of fp_rnd_arb against
// a queue-based reference model of the two sources and the output stage.
module tb_fp_rnd_arb;
  localparam int DEPTH  = 4;
  localparam int MARGIN = 2;
  localparam int SMAX   = 8;
  localparam int TAG_W  = 5;
`ifdef FP_RND_ARB_TAG_EN
  localparam int EW = 85 + TAG_W;
`else
  localparam int EW = 85;
`endif
  typedef logic [EW-1:0] ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fma_valid_i = 1'b0;
  logic        fdiv_valid_i = 1'b0;
  logic        rnd_ready_i = 1'b0;
  logic [84:0] fma_rnd_i = '0;
  logic [84:0] fdiv_rnd_i = '0;
  logic        fdiv_ready_o, fma_afull_o, rnd_valid_o;
  logic [84:0] rnd_o;
  logic        rnd_src_o, overflow_o;
`ifdef FP_RND_ARB_TAG_EN
  logic [TAG_W-1:0] fma_tag_i = '0;
  logic [TAG_W-1:0] fdiv_tag_i = '0;
  logic [TAG_W-1:0] rnd_tag_o;
`endif

  fp_rnd_arb #(
    .DEPTH(DEPTH), .AFULL_MARGIN(MARGIN),
    .STARVE_MAX(SMAX), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst(rst),
    .fma_valid_i(fma_valid_i), .fma_rnd_i(fma_rnd_i),
    .fdiv_valid_i(fdiv_valid_i), .fdiv_rnd_i(fdiv_rnd_i),
`ifdef FP_RND_ARB_TAG_EN
    .fma_tag_i(fma_tag_i), .fdiv_tag_i(fdiv_tag_i),
    .rnd_tag_o(rnd_tag_o),
`endif
    .fdiv_ready_o(fdiv_ready_o), .fma_afull_o(fma_afull_o),
    .rnd_valid_o(rnd_valid_o), .rnd_ready_i(rnd_ready_i),
    .rnd_o(rnd_o), .rnd_src_o(rnd_src_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [84:0] r85();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[84:0];
  endfunction

  function automatic ent_t fma_ent();
`ifdef FP_RND_ARB_TAG_EN
    return {fma_tag_i, fma_rnd_i};
`else
    return fma_rnd_i;
`endif
  endfunction

  function automatic ent_t fdiv_ent();
`ifdef FP_RND_ARB_TAG_EN
    return {fdiv_tag_i, fdiv_rnd_i};
`else
    return fdiv_rnd_i;
`endif
  endfunction

  function automatic ent_t out_ent();
`ifdef FP_RND_ARB_TAG_EN
    return {rnd_tag_o, rnd_o};
`else
    return rnd_o;
`endif
  endfunction

  // Reference model: one queue per source plus the output slot.
  ent_t q_fma[$];
  ent_t q_fdiv[$];
  bit   m_v, m_src, m_ovf;
  ent_t m_d;
  int   m_starve;

  always @(posedge clk) begin : model
    bit ld, fh, dh, din, take_d, used_f, used_d;
    if (rst) begin
      q_fma.delete();
      q_fdiv.delete();
      m_v = 0; m_src = 0; m_ovf = 0; m_d = '0; m_starve = 0;
    end else begin
      ld = !m_v || rnd_ready_i;
      din = fdiv_valid_i && q_fdiv.size() < DEPTH;
      fh = q_fma.size() > 0 || fma_valid_i;
      dh = q_fdiv.size() > 0 || din;
      used_f = 0;
      used_d = 0;
      if (ld && (fh || dh)) begin
        take_d = dh && (!fh || m_starve >= SMAX);
        m_v = 1;
        m_src = take_d;
        if (take_d) begin
          if (q_fdiv.size() > 0) m_d = q_fdiv.pop_front();
          else begin m_d = fdiv_ent(); used_d = 1; end
          m_starve = 0;
        end else begin
          if (q_fma.size() > 0) m_d = q_fma.pop_front();
          else begin m_d = fma_ent(); used_f = 1; end
          if (dh && m_starve < SMAX) m_starve++;
        end
      end else if (ld) begin
        m_v = 0;
      end
      if (fma_valid_i && !used_f) begin
        if (q_fma.size() < DEPTH) q_fma.push_back(fma_ent());
        else m_ovf = 1;
      end
      if (din && !used_d) q_fdiv.push_back(fdiv_ent());
    end
  end

  always @(negedge clk) begin : compare
    if (cmp_en) begin
      chk("m_valid", 128'(rnd_valid_o), 128'(m_v));
      if (m_v) begin
        chk("m_data", 128'(out_ent()), 128'(m_d));
        chk("m_src", 128'(rnd_src_o), 128'(m_src));
      end
      chk("m_fdiv_ready", 128'(fdiv_ready_o), 128'(q_fdiv.size() != DEPTH));
      chk("m_afull", 128'(fma_afull_o), 128'(q_fma.size() >= DEPTH - MARGIN));
      chk("m_ovf", 128'(overflow_o), 128'(m_ovf));
    end
  end

  int fpct [6] = '{50, 90, 20, 70, 95, 30};
  int dpct [6] = '{30, 60, 80, 20, 50, 90};
  int rpct [6] = '{80, 40, 95, 20, 60, 100};

  initial begin : stim
    bit hold;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_valid", 128'(rnd_valid_o), 128'd0);
    chk("rst_data", 128'(rnd_o), 128'd0);
    chk("rst_src", 128'(rnd_src_o), 128'd0);
    chk("rst_ovf", 128'(overflow_o), 128'd0);
    chk("rst_afull", 128'(fma_afull_o), 128'd0);
    chk("rst_fdiv_ready", 128'(fdiv_ready_o), 128'd1);

    // single FMA record, one cycle latency
    rst = 1'b0;
    rnd_ready_i = 1'b1;
    fma_valid_i = 1'b1;
    fma_rnd_i = 85'h1;
`ifdef FP_RND_ARB_TAG_EN
    fma_tag_i = 5'h03;
    fdiv_tag_i = 5'h1F;
`endif
    @(negedge clk);
    chk("one_valid", 128'(rnd_valid_o), 128'd1);
    chk("one_data", 128'(rnd_o), 128'd1);
    chk("one_src", 128'(rnd_src_o), 128'd0);
    chk("one_fdiv_ready", 128'(fdiv_ready_o), 128'd1);

    // simultaneous arrival
    fma_rnd_i = 85'hA;
    fdiv_valid_i = 1'b1;
    fdiv_rnd_i = 85'hB;
    @(negedge clk);
    chk("both_src0", 128'(rnd_src_o), 128'd0);
    chk("both_data0", 128'(rnd_o), 128'hA);
`ifdef FP_RND_ARB_TAG_EN
    chk("both_tag0", 128'(rnd_tag_o), 128'h03);
`endif
    fma_valid_i = 1'b0;
    fdiv_valid_i = 1'b0;
    @(negedge clk);
    chk("both_valid1", 128'(rnd_valid_o), 128'd1);
    chk("both_src1", 128'(rnd_src_o), 128'd1);
    chk("both_data1", 128'(rnd_o), 128'hB);
`ifdef FP_RND_ARB_TAG_EN
    chk("both_tag1", 128'(rnd_tag_o), 128'h1F);
`endif
    @(negedge clk);
    chk("both_idle", 128'(rnd_valid_o), 128'd0);

    // FDIV starves behind a continuous FMA stream
    fdiv_valid_i = 1'b1;
    fdiv_rnd_i = 85'hC;
    for (int i = 0; i < 9; i++) begin
      fma_valid_i = 1'b1;
      fma_rnd_i = 85'h100 + 85'(i);
      @(negedge clk);
      fdiv_valid_i = 1'b0;
      chk("starve_src", 128'(rnd_src_o), 128'(i == 8));
    end
    chk("starve_data", 128'(rnd_o), 128'hC);
    fma_valid_i = 1'b0;
    @(negedge clk);
    chk("starve_tail", 128'(rnd_o), 128'h108);
    fma_valid_i = 1'b1;
    fma_rnd_i = 85'h200;
    fdiv_valid_i = 1'b1;
    fdiv_rnd_i = 85'h201;
    @(negedge clk);
    chk("starve_clr", 128'(rnd_src_o), 128'd0);
    fma_valid_i = 1'b0;
    fdiv_valid_i = 1'b0;
    repeat (2) @(negedge clk);

    // FMA overflow with the rounder stalled
    rnd_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      fma_valid_i = 1'b1;
      fma_rnd_i = 85'h300 + 85'(i);
      @(negedge clk);
      if (i == 1) chk("afull_1", 128'(fma_afull_o), 128'd0);
      if (i == 2) chk("afull_2", 128'(fma_afull_o), 128'd1);
    end
    chk("ovf_set", 128'(overflow_o), 128'd1);
    chk("ovf_head", 128'(rnd_o), 128'h300);
    fma_valid_i = 1'b0;
    @(negedge clk);
    chk("ovf_sticky", 128'(overflow_o), 128'd1);
    rnd_ready_i = 1'b1;
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      chk("ovf_order", 128'(rnd_o), 128'h300 + 128'(k));
    end
    @(negedge clk);
    chk("ovf_drained", 128'(rnd_valid_o), 128'd0);

    // FDIV back-pressure
    rnd_ready_i = 1'b0;
    fdiv_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fdiv_rnd_i = 85'h400 + 85'(i);
      @(negedge clk);
    end
    chk("fdiv_full", 128'(fdiv_ready_o), 128'd0);
    fdiv_rnd_i = 85'h405;
    @(negedge clk);
    chk("fdiv_held", 128'(fdiv_ready_o), 128'd0);
    chk("fdiv_head", 128'(rnd_o), 128'h400);
    rnd_ready_i = 1'b1;
    @(negedge clk);
    chk("fdiv_pop", 128'(rnd_o), 128'h401);
    chk("fdiv_room", 128'(fdiv_ready_o), 128'd1);
    rnd_ready_i = 1'b0;
    @(negedge clk);
    fdiv_valid_i = 1'b0;
    chk("fdiv_refull", 128'(fdiv_ready_o), 128'd0);

    // reset in the middle of traffic
    fma_valid_i = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_valid", 128'(rnd_valid_o), 128'd0);
    chk("mrst_data", 128'(rnd_o), 128'd0);
    chk("mrst_ovf", 128'(overflow_o), 128'd0);
    chk("mrst_fdiv_ready", 128'(fdiv_ready_o), 128'd1);
    chk("mrst_afull", 128'(fma_afull_o), 128'd0);
    rst = 1'b0;
    fma_valid_i = 1'b0;

    // randomized traffic in phases of differing load
    hold = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(0, 399) == 0;
      rnd_ready_i = $urandom_range(0, 99) < rpct[c / 500];
      fma_valid_i = $urandom_range(0, 99) < fpct[c / 500];
      fma_rnd_i = r85();
`ifdef FP_RND_ARB_TAG_EN
      fma_tag_i = TAG_W'($urandom());
`endif
      if (!hold) begin
        fdiv_valid_i = $urandom_range(0, 99) < dpct[c / 500];
        fdiv_rnd_i = r85();
`ifdef FP_RND_ARB_TAG_EN
        fdiv_tag_i = TAG_W'($urandom());
`endif
      end
      hold = fdiv_valid_i && !fdiv_ready_o && !rst;
      @(negedge clk);
    end
    rst = 1'b0;
    fma_valid_i = 1'b0;
    fdiv_valid_i = 1'b0;
    rnd_ready_i = 1'b1;
    repeat (12) @(negedge clk);
    chk("final_idle", 128'(rnd_valid_o), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
